// File: rtl/stream_upsize_buf.sv
// Narrow-to-wide stream packer with an accumulator, a registered output stage and
// an optional idle-timeout flush of partially filled words.
module stream_upsize_buf #(
  parameter int T_DATA_WIDTH  = 8,
  parameter int T_DATA_RATIO  = 4,
  parameter int FLUSH_TIMEOUT = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic                                 s_last_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  output logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] m_data_o,
  output logic [T_DATA_RATIO-1:0]              m_keep_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam int OW       = T_DATA_WIDTH * T_DATA_RATIO;
  localparam int CW       = $clog2(T_DATA_RATIO + 1);
  localparam int IW       = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam int IDLE_LIM = (FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] FULL_CNT = CW'(T_DATA_RATIO);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIM);

  logic [OW-1:0]           acc_data;
  logic [CW-1:0]           count;
  logic                    acc_last;
  logic                    done;
  logic [IW-1:0]           idle_cnt;

  logic [OW-1:0]           out_data;
  logic [T_DATA_RATIO-1:0] out_keep;
  logic                    out_last;
  logic                    out_valid;

  logic [OW-1:0]           nxt_data;
  logic [CW-1:0]           nxt_count;
  logic                    nxt_last;
  logic                    accept;
  logic                    out_free;
  logic                    beat_done;
  logic                    tmo;
  logic                    complete;
  logic                    idle_clr;

  function automatic logic [T_DATA_RATIO-1:0] keep_of(input logic [CW-1:0] n);
    logic [T_DATA_RATIO-1:0] k;
    k = '0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      k[i] = (CW'(i) < n);
    end
    return k;
  endfunction

  always_comb begin
    accept   = s_valid_i && !done;
    out_free = !out_valid || m_ready_i;
    nxt_data = acc_data;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (accept && (count == CW'(i))) begin
        nxt_data[i*T_DATA_WIDTH +: T_DATA_WIDTH] = s_data_i;
      end
    end
    nxt_count = accept ? (count + CW'(1)) : count;
    nxt_last  = accept && s_last_i;
    beat_done = accept && (s_last_i || (nxt_count == FULL_CNT));
    // A beat arriving on the limit cycle wins: tmo requires !accept.
    tmo       = (FLUSH_TIMEOUT > 0) && !accept && !done &&
                (count != '0) && (idle_cnt == IDLE_MAX);
    complete  = beat_done || tmo;
    idle_clr  = (FLUSH_TIMEOUT == 0) || accept || complete || done || (count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data  <= '0;
      count     <= '0;
      acc_last  <= 1'b0;
      done      <= 1'b0;
      idle_cnt  <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (done) begin
        // Parked word moves up as soon as the output register drains.
        if (m_ready_i) begin
          out_data  <= acc_data;
          out_keep  <= keep_of(count);
          out_last  <= acc_last;
          out_valid <= 1'b1;
          acc_data  <= '0;
          count     <= '0;
          acc_last  <= 1'b0;
          done      <= 1'b0;
        end
      end else if (complete) begin
        if (out_free) begin
          out_data  <= nxt_data;
          out_keep  <= keep_of(nxt_count);
          out_last  <= nxt_last;
          out_valid <= 1'b1;
          acc_data  <= '0;
          count     <= '0;
          acc_last  <= 1'b0;
        end else begin
          acc_data  <= nxt_data;
          count     <= nxt_count;
          acc_last  <= nxt_last;
          done      <= 1'b1;
        end
      end else begin
        acc_data <= nxt_data;
        count    <= nxt_count;
        if (m_ready_i) begin
          out_valid <= 1'b0;
        end
      end
      idle_cnt <= idle_clr ? '0 : (idle_cnt + IW'(1));
    end
  end

  assign s_ready_o = !done;
  assign m_data_o  = out_data;
  assign m_keep_o  = out_keep;
  assign m_last_o  = out_last;
  assign m_valid_o = out_valid;

endmodule

// File: tb/tb_stream_upsize_buf.sv
// Bench for stream_upsize_buf: R=4 with flush timeout 4, and R=2 without timeout,
// each compared every cycle against a word-level queue model.
module tb_stream_upsize_buf;

  localparam int W = 8;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid [2];
  logic        s_last  [2];
  logic [7:0]  s_data  [2];
  logic        s_ready [2];
  logic        m_ready [2];
  logic        m_valid [2];
  logic        m_last  [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_keep  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int R  = (g == 0) ? 4 : 2;
    localparam int FT = (g == 0) ? 4 : 0;

    logic [W*R-1:0] dw;
    logic [R-1:0]   kw;

    stream_upsize_buf #(
      .T_DATA_WIDTH (W),
      .T_DATA_RATIO (R),
      .FLUSH_TIMEOUT(FT)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data_i (s_data[g]),
      .s_last_i (s_last[g]),
      .s_valid_i(s_valid[g]),
      .s_ready_o(s_ready[g]),
      .m_data_o (dw),
      .m_keep_o (kw),
      .m_last_o (m_last[g]),
      .m_valid_o(m_valid[g]),
      .m_ready_i(m_ready[g])
    );

    assign m_data[g] = 32'(dw);
    assign m_keep[g] = 4'(kw);

    // Model: completed words wait in exp_q (head = output register); at most two
    // completed words can be held, so input stalls when two are pending.
    word_t      exp_q [$];
    logic [7:0] part_q[$];
    logic [7:0] log_q [$];
    int         idle = 0;

    task automatic push_word(input logic lst);
      word_t w;
      w.data = '0;
      w.keep = '0;
      w.last = lst;
      for (int i = 0; i < part_q.size(); i++) begin
        w.data[i*8 +: 8] = part_q[i];
        w.keep[i]        = 1'b1;
      end
      exp_q.push_back(w);
      part_q.delete();
    endtask

    initial forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        part_q.delete();
        log_q.delete();
        idle = 0;
      end else begin
        bit rdy, acc, xfer;
        rdy  = exp_q.size() < 2;
        xfer = (exp_q.size() > 0) && m_ready[g];
        acc  = s_valid[g] && rdy;
        if (xfer) void'(exp_q.pop_front());
        if (acc) begin
          part_q.push_back(s_data[g]);
          log_q.push_back(s_data[g]);
          idle = 0;
          if (part_q.size() == R || s_last[g]) push_word(s_last[g]);
        end else if (part_q.size() > 0) begin
          idle++;
          if (FT > 0 && idle == FT) begin
            push_word(1'b0);
            idle = 0;
          end
        end else begin
          idle = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("rst_valid%0d", g), 32'(m_valid[g]), 32'd0);
        chk($sformatf("rst_ready%0d", g), 32'(s_ready[g]), 32'd1);
        chk($sformatf("rst_data%0d", g), m_data[g], 32'd0);
        chk($sformatf("rst_keep%0d", g), 32'(m_keep[g]), 32'd0);
        chk($sformatf("rst_last%0d", g), 32'(m_last[g]), 32'd0);
      end else begin
        chk($sformatf("valid%0d", g), 32'(m_valid[g]), 32'(exp_q.size() > 0));
        chk($sformatf("ready%0d", g), 32'(s_ready[g]), 32'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
          chk($sformatf("data%0d", g), m_data[g], exp_q[0].data);
          chk($sformatf("keep%0d", g), 32'(m_keep[g]), 32'(exp_q[0].keep));
          chk($sformatf("last%0d", g), 32'(m_last[g]), 32'(exp_q[0].last));
        end
        if (m_valid[g] && m_ready[g]) begin
          for (int i = 0; i < R; i++) begin
            if (m_keep[g][i]) begin
              if (log_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream%0d: actual=extra lane %0d required=no beat", g, i);
              end else begin
                chk($sformatf("stream%0d", g), 32'(m_data[g][i*8 +: 8]), 32'(log_q.pop_front()));
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in(input int g);
    s_valid[g] = 1'b0;
    s_last[g]  = 1'b0;
  endtask

  task automatic send(input int g, input logic [7:0] d, input logic l);
    logic a;
    int   n;
    s_valid[g] = 1'b1;
    s_data[g]  = d;
    s_last[g]  = l;
    for (n = 0; n < 50; n++) begin
      a = s_ready[g];
      tick();
      if (a) break;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL send%0d: actual=stalled required=accepted", g);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({nm, "_valid"}, 32'(m_valid[0]), 32'd1);
    chk({nm, "_data"}, m_data[0], d);
    chk({nm, "_keep"}, 32'(m_keep[0]), 32'(k));
    chk({nm, "_last"}, 32'(m_last[0]), 32'(l));
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      s_valid[g] = 1'b0;
      s_last[g]  = 1'b0;
      s_data[g]  = '0;
      m_ready[g] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;

    // full word, one-cycle latency, no input bubbles
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    send(0, 8'h44, 1'b1);
    idle_in(0);
    chk_word("full", 32'h44332211, 4'b1111, 1'b1);
    chk("full_ready", 32'(s_ready[0]), 32'd1);

    // short packet, next beat restarts in lane 0
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b1);
    idle_in(0);
    chk_word("short", 32'h0000BBAA, 4'b0011, 1'b1);
    send(0, 8'hCC, 1'b1);
    idle_in(0);
    chk_word("lane0", 32'h000000CC, 4'b0001, 1'b1);
    tick();

    // backpressure: second word parks, ninth beat stalls
    m_ready[0] = 1'b0;
    for (int i = 1; i <= 8; i++) send(0, 8'(i), 1'b0);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h09;
    s_last[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall", 32'(s_ready[0]), 32'd0);
      chk_word("bp_hold", 32'h04030201, 4'b1111, 1'b0);
      tick();
    end
    m_ready[0] = 1'b1;
    tick();
    chk_word("bp_second", 32'h08070605, 4'b1111, 1'b0);
    chk("bp_ready_back", 32'(s_ready[0]), 32'd1);
    tick();
    idle_in(0);
    chk_word("bp_ninth", 32'h00000009, 4'b0001, 1'b1);

    // idle-timeout flush after 4 idle cycles
    send(0, 8'h5A, 1'b0);
    idle_in(0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("tmo_wait", 32'(m_valid[0]), 32'd0);
    end
    tick();
    chk_word("tmo_flush", 32'h0000005A, 4'b0001, 1'b0);

    // beat on the 4th idle cycle beats the timeout
    send(0, 8'h6B, 1'b0);
    idle_in(0);
    repeat (3) tick();
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h7C;
    tick();
    chk("tmo_beat_wins", 32'(m_valid[0]), 32'd0);
    s_data[0] = 8'h8D;
    s_last[0] = 1'b1;
    tick();
    idle_in(0);
    chk_word("tmo_lane1", 32'h008D7C6B, 4'b0111, 1'b1);
    tick();

    // reset mid-packet discards the partial word
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    idle_in(0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid[0]), 32'd0);
    chk("mid_rst_ready", 32'(s_ready[0]), 32'd1);
    tick();
    rst = 1'b0;
    send(0, 8'hA1, 1'b0);
    send(0, 8'hA2, 1'b0);
    send(0, 8'hA3, 1'b0);
    send(0, 8'hA4, 1'b0);
    idle_in(0);
    chk_word("post_rst", 32'hA4A3A2A1, 4'b1111, 1'b0);

    // random valid/ready on both widths
    for (int c = 0; c < 4000; c++) begin
      for (int g = 0; g < 2; g++) begin
        s_valid[g] = 1'($urandom_range(0, 1));
        s_data[g]  = 8'($urandom);
        s_last[g]  = ($urandom_range(0, 5) == 0);
        m_ready[g] = 1'($urandom_range(0, 1));
      end
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      idle_in(g);
      m_ready[g] = 1'b1;
    end
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
